// File: rtl/equilibrium_maxxing_pkg.sv
// Shared definitions for the play generator: FSM state codes, LED count and
// small index helpers used by both the datapath and the bus interface.
package equilibrium_maxxing_pkg;

  localparam int unsigned NUM_LEDS = 11;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned TRY_W    = 5;

  typedef enum logic [2:0] {
    OCIOSO  = 3'b000,
    SORTEIO = 3'b001,
    ESPERA  = 3'b010,
    CONTA   = 3'b011,
    PONTO   = 3'b100
  } estado_t;

  // Deterministic fallback target: next position, wrapping 10 -> 0.
  function automatic logic [IDX_W-1:0] proximo_idx(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(NUM_LEDS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/gerador_jogada_if.sv
// Bus between the control unit and the play generator: request/level/position
// inputs towards the generator, target LEDs and scoring pulse back.
interface gerador_jogada_if;
  import equilibrium_maxxing_pkg::*;

  logic                gerar_nova_jogada;
  logic [1:0]          nivel_reg;
  logic [IDX_W-1:0]    posicao_idx;
  logic                posicao_valida;
  logic [NUM_LEDS-1:0] leds;
  logic [IDX_W-1:0]    alvo_idx;
  logic                ponto_evento;
  logic [2:0]          db_estado;

  modport master (
    output gerar_nova_jogada, nivel_reg, posicao_idx, posicao_valida,
    input  leds, alvo_idx, ponto_evento, db_estado
  );

  modport slave (
    input  gerar_nova_jogada, nivel_reg, posicao_idx, posicao_valida,
    output leds, alvo_idx, ponto_evento, db_estado
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// The seed must be nonzero or the register locks up at zero.
module lfsr8 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gerador_jogada.sv
// Play generator: draws a random target LED, then waits for the platform to
// hold that position for a level-dependent number of cycles before scoring.
module gerador_jogada
  import equilibrium_maxxing_pkg::*;
#(
  parameter int unsigned HOLD_N0   = 8,
  parameter int unsigned HOLD_N1   = 16,
  parameter int unsigned HOLD_N2   = 32,
  parameter int unsigned HOLD_N3   = 64,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  gerador_jogada_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM0 = CNT_W'(HOLD_N0 - 1);
  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(HOLD_N1 - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(HOLD_N2 - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(HOLD_N3 - 1);
  localparam logic [TRY_W-1:0] MAX_REJ = TRY_W'(16);

  estado_t             estado_q, estado_d;
  logic                gnj_q;
  logic [IDX_W-1:0]    alvo_q, alvo_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    lim_q, lim_d;
  logic [TRY_W-1:0]    tent_q, tent_d;

  logic [7:0]          lfsr_q;
  logic [3:0]          unused_lfsr;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    prox;
  logic [NUM_LEDS-1:0] cand_dec;
  logic [NUM_LEDS-1:0] prox_dec;
  logic [CNT_W-1:0]    lim_sel;
  logic                sobe;
  logic                alinhado;
  logic                cand_ok;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign cand        = lfsr_q[3:0];
  assign unused_lfsr = lfsr_q[7:4];
  assign prox        = proximo_idx(alvo_q);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_dec
      assign cand_dec[gi] = (cand == IDX_W'(gi));
      assign prox_dec[gi] = (prox == IDX_W'(gi));
    end
  endgenerate

  // Positions 11..15 are excluded explicitly so they can never score.
  assign sobe     = bus.gerar_nova_jogada & ~gnj_q;
  assign alinhado = bus.posicao_valida && (bus.posicao_idx <= IDX_W'(NUM_LEDS - 1))
                    && (bus.posicao_idx == alvo_q);
  assign cand_ok  = (cand <= IDX_W'(NUM_LEDS - 1)) && (cand != alvo_q);

  always_comb begin
    case (bus.nivel_reg)
      2'd0:    lim_sel = LIM0;
      2'd1:    lim_sel = LIM1;
      2'd2:    lim_sel = LIM2;
      default: lim_sel = LIM3;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    alvo_d   = alvo_q;
    leds_d   = leds_q;
    cnt_d    = cnt_q;
    lim_d    = lim_q;
    tent_d   = tent_q;
    case (estado_q)
      OCIOSO: begin
        if (sobe) begin
          estado_d = SORTEIO;
          tent_d   = '0;
        end
      end
      SORTEIO: begin
        if (tent_q == MAX_REJ) begin
          alvo_d   = prox;
          leds_d   = prox_dec;
          estado_d = ESPERA;
        end else if (cand_ok) begin
          alvo_d   = cand;
          leds_d   = cand_dec;
          estado_d = ESPERA;
        end else begin
          tent_d = tent_q + TRY_W'(1);
        end
      end
      ESPERA: begin
        if (sobe) begin
          estado_d = SORTEIO;
          leds_d   = '0;
          tent_d   = '0;
        end else if (alinhado) begin
          estado_d = CONTA;
          cnt_d    = '0;
          lim_d    = lim_sel;
        end
      end
      CONTA: begin
        if (sobe) begin
          estado_d = SORTEIO;
          leds_d   = '0;
          tent_d   = '0;
        end else if (!alinhado) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else if (cnt_q == lim_q) begin
          estado_d = PONTO;
          leds_d   = '0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      PONTO: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      gnj_q    <= 1'b0;
      alvo_q   <= '0;
      leds_q   <= '0;
      cnt_q    <= '0;
      lim_q    <= '0;
      tent_q   <= '0;
    end else begin
      estado_q <= estado_d;
      gnj_q    <= bus.gerar_nova_jogada;
      alvo_q   <= alvo_d;
      leds_q   <= leds_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      tent_q   <= tent_d;
    end
  end

  assign bus.leds         = leds_q;
  assign bus.alvo_idx     = alvo_q;
  assign bus.ponto_evento = (estado_q == PONTO);
  assign bus.db_estado    = estado_q;

endmodule
